// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: Moore FSM sequencing a shared-ALU, shared-memory datapath
// through fetch/decode/execute/memory/writeback, with memory stalls and a multiply wait.
module mc_control_unit #(
    parameter int unsigned     OP_W       = 6,
    parameter int unsigned     ALUOP_W    = 4,
    parameter int unsigned     MUL_CYCLES = 4,
    parameter logic [OP_W-1:0] MULT_FUNCT = OP_W'(6'b011000)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic [OP_W-1:0]    funct_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemtoReg_o,
    output logic               RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic               ZeroExt_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic [1:0]         PCSource_o,
    output logic [1:0]         branchType_o,
    output logic               illegal_o,
    output logic               busy_mul_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BGEZ  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_BNEZ  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_BGT   = OP_W'(6'b000111);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(4'b0000);
    localparam logic [ALUOP_W-1:0] ALU_BEQ  = ALUOP_W'(4'b0001);
    localparam logic [ALUOP_W-1:0] ALU_R    = ALUOP_W'(4'b0010);
    localparam logic [ALUOP_W-1:0] ALU_ADDI = ALUOP_W'(4'b0100);
    localparam logic [ALUOP_W-1:0] ALU_ORI  = ALUOP_W'(4'b0101);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(4'b1000);
    localparam logic [ALUOP_W-1:0] ALU_BGEZ = ALUOP_W'(4'b1001);
    localparam logic [ALUOP_W-1:0] ALU_BNEZ = ALUOP_W'(4'b1010);
    localparam logic [ALUOP_W-1:0] ALU_BGT  = ALUOP_W'(4'b1011);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MULW   = 4'd4,
        S_RWB    = 4'd5,
        S_IEXEC  = 4'd6,
        S_IWB    = 4'd7,
        S_MEMADR = 4'd8,
        S_MEMRD  = 4'd9,
        S_MEMWB  = 4'd10,
        S_MEMWR  = 4'd11,
        S_BRANCH = 4'd12,
        S_JUMP   = 4'd13
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  mul_cnt_q, mul_cnt_d;
    logic [OP_W-1:0]   op_q, op_d;

    // State, multiply counter and the opcode captured in DECODE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            mul_cnt_q <= '0;
            op_q      <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            op_q      <= op_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mul_cnt_d     = mul_cnt_q;
        op_d          = op_q;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ZeroExt_o     = 1'b0;
        ALU_op_o      = ALU_ADD;
        PCSource_o    = 2'b00;
        branchType_o  = 2'b00;
        illegal_o     = 1'b0;
        busy_mul_o    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                if (mem_ready_i) begin
                    IRWrite_o = 1'b1;
                    PCWrite_o = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                op_d      = instr_op_i;
                case (instr_op_i)
                    OP_RTYPE:                    state_d = S_EXEC;
                    OP_ADDI, OP_ORI, OP_LUI:     state_d = S_IEXEC;
                    OP_LW, OP_SW:                state_d = S_MEMADR;
                    OP_BEQ, OP_BGEZ, OP_BNEZ,
                    OP_BGT:                      state_d = S_BRANCH;
                    OP_J:                        state_d = S_JUMP;
                    default: begin
                        illegal_o = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALU_op_o  = ALU_R;
                // A single-cycle multiplier completes here, so MULW is skipped
                if (funct_i == MULT_FUNCT && MUL_LOAD != '0) begin
                    mul_cnt_d = MUL_LOAD;
                    state_d   = S_MULW;
                end else begin
                    state_d = S_RWB;
                end
            end
            S_MULW: begin
                busy_mul_o = 1'b1;
                ALUSrcA_o  = 1'b1;
                ALU_op_o   = ALU_R;
                mul_cnt_d  = mul_cnt_q - CNT_W'(1);
                if (mul_cnt_q <= CNT_W'(1)) begin
                    mul_cnt_d = '0;
                    state_d   = S_RWB;
                end
            end
            S_RWB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
                state_d    = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                case (op_q)
                    OP_ORI: begin
                        ZeroExt_o = 1'b1;
                        ALU_op_o  = ALU_ORI;
                    end
                    OP_LUI: begin
                        ZeroExt_o = 1'b1;
                        ALU_op_o  = ALU_LUI;
                    end
                    default: ALU_op_o = ALU_ADDI;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite_o = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                case (op_q)
                    OP_BGEZ: begin
                        ALU_op_o     = ALU_BGEZ;
                        branchType_o = 2'd1;
                    end
                    OP_BNEZ: begin
                        ALU_op_o     = ALU_BNEZ;
                        branchType_o = 2'd2;
                    end
                    OP_BGT: begin
                        ALU_op_o     = ALU_BGT;
                        branchType_o = 2'd3;
                    end
                    default: ALU_op_o = ALU_BEQ;
                endcase
                state_d = S_FETCH;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: each scenario queues per-cycle stimulus with the
// expected control vector; entries are popped and compared mid-cycle.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;

    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, ze, ill, busy;
    logic [1:0] sb, pcs, bt;
    logic [3:0] alu;
    logic pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rdst1, rw1, sa1, ze1, ill1, busy1;
    logic [1:0] sb1, pcs1, bt1;
    logic [3:0] alu1;

    logic [22:0] outv, outv1;
    assign outv  = {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, ze, alu, pcs, bt, ill, busy};
    assign outv1 = {pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rdst1, rw1, sa1, sb1, ze1, alu1, pcs1, bt1, ill1, busy1};

    mc_control_unit #(.MUL_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst_n), .instr_op_i(op), .funct_i(funct), .mem_ready_i(mem_ready),
        .PCWrite_o(pcw), .PCWriteCond_o(pcwc), .IorD_o(iord), .MemRead_o(mr), .MemWrite_o(mw),
        .IRWrite_o(irw), .MemtoReg_o(m2r), .RegDst_o(rdst), .RegWrite_o(rw), .ALUSrcA_o(sa),
        .ALUSrcB_o(sb), .ZeroExt_o(ze), .ALU_op_o(alu), .PCSource_o(pcs), .branchType_o(bt),
        .illegal_o(ill), .busy_mul_o(busy)
    );

    mc_control_unit #(.MUL_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .instr_op_i(op), .funct_i(funct), .mem_ready_i(mem_ready),
        .PCWrite_o(pcw1), .PCWriteCond_o(pcwc1), .IorD_o(iord1), .MemRead_o(mr1), .MemWrite_o(mw1),
        .IRWrite_o(irw1), .MemtoReg_o(m2r1), .RegDst_o(rdst1), .RegWrite_o(rw1), .ALUSrcA_o(sa1),
        .ALUSrcB_o(sb1), .ZeroExt_o(ze1), .ALU_op_o(alu1), .PCSource_o(pcs1), .branchType_o(bt1),
        .illegal_o(ill1), .busy_mul_o(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [22:0] e;
        logic [22:0] e1;
        bit          chk1;
    } item_t;

    item_t q[$];
    item_t it;
    int errors = 0;
    int checks = 0;
    int cyc;

    function automatic logic [22:0] ov(input logic pcw_, pcwc_, iord_, mr_, mw_, irw_, m2r_, rd_, rw_, sa_,
                                       input logic [1:0] sb_, input logic ze_, input logic [3:0] alu_,
                                       input logic [1:0] pcs_, bt_, input logic ill_, busy_);
        return {pcw_, pcwc_, iord_, mr_, mw_, irw_, m2r_, rd_, rw_, sa_, sb_, ze_, alu_, pcs_, bt_, ill_, busy_};
    endfunction

    function automatic logic [22:0] e_fetch(input logic r);
        return ov(r, 0, 0, 1, 0, r, 0, 0, 0, 0, 2'b01, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [22:0] e_decode(input logic il);
        return ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 4'b0000, 2'b00, 2'b00, il, 0);
    endfunction
    function automatic logic [22:0] e_exec(input logic b);
        return ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'b0010, 2'b00, 2'b00, 0, b);
    endfunction
    function automatic logic [22:0] e_rwb();
        return ov(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [22:0] e_iexec(input logic z, input logic [3:0] a);
        return ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, z, a, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [22:0] e_iwb();
        return ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [22:0] e_memadr();
        return ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [22:0] e_memrd();
        return ov(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [22:0] e_memwb();
        return ov(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [22:0] e_memwr();
        return ov(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [22:0] e_branch(input logic [3:0] a, input logic [1:0] t);
        return ov(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, a, 2'b01, t, 0, 0);
    endfunction
    function automatic logic [22:0] e_jump();
        return ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 2'b10, 2'b00, 0, 0);
    endfunction

    task automatic push(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic [22:0] e, input logic [22:0] e1, input bit c);
        item_t x;
        x.rdy = r; x.op = o; x.fn = f; x.e = e; x.e1 = e1; x.chk1 = c;
        q.push_back(x);
    endtask

    task automatic do_reset(input logic [5:0] o, input logic [5:0] f);
        rst_n = 1'b0; op = o; funct = f; mem_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (outv !== 23'd0) begin errors++; $display("FAIL reset_outputs: got %h want 000000", outv); end
        do_reset(6'd0, 6'd0);
        push(1, 6'd0, 6'd0, 23'd0, 23'd0, 0);
        push(0, 6'd0, 6'd0, e_fetch(0), 23'd0, 0);
        push(0, 6'd0, 6'd0, e_fetch(0), 23'd0, 0);
        cyc = 0;
        while (q.size() > 0) begin
            mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
            @(negedge clk); it = q.pop_front(); checks++;
            if (outv !== it.e) begin errors++; $display("FAIL reset_seq c%0d: got %h want %h", cyc, outv, it.e); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_rtype();
        do_reset(6'd0, 6'b100000);
        push(1, 6'd0, 6'b100000, 23'd0, 23'd0, 0);
        push(1, 6'd0, 6'b100000, e_fetch(1), 23'd0, 0);
        push(1, 6'd0, 6'b100000, e_decode(0), 23'd0, 0);
        push(1, 6'd0, 6'b100000, e_exec(0), 23'd0, 0);
        push(1, 6'd0, 6'b100000, e_rwb(), 23'd0, 0);
        push(1, 6'd0, 6'b100000, e_fetch(1), 23'd0, 0);
        cyc = 0;
        while (q.size() > 0) begin
            mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
            @(negedge clk); it = q.pop_front(); checks++;
            if (outv !== it.e) begin errors++; $display("FAIL rtype c%0d: got %h want %h", cyc, outv, it.e); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_lw_stall();
        do_reset(6'b100011, 6'd0);
        push(1, 6'b100011, 6'd0, 23'd0, 23'd0, 0);
        push(1, 6'b100011, 6'd0, e_fetch(1), 23'd0, 0);
        push(1, 6'b100011, 6'd0, e_decode(0), 23'd0, 0);
        push(0, 6'b100011, 6'd0, e_memadr(), 23'd0, 0);
        for (int i = 0; i < 3; i++) push(0, 6'b100011, 6'd0, e_memrd(), 23'd0, 0);
        push(1, 6'b100011, 6'd0, e_memrd(), 23'd0, 0);
        push(0, 6'b100011, 6'd0, e_memwb(), 23'd0, 0);
        push(0, 6'b100011, 6'd0, e_fetch(0), 23'd0, 0);
        cyc = 0;
        while (q.size() > 0) begin
            mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
            @(negedge clk); it = q.pop_front(); checks++;
            if (outv !== it.e) begin errors++; $display("FAIL lw_stall c%0d: got %h want %h", cyc, outv, it.e); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_mul();
        logic [5:0] mf;
        mf = 6'b011000;
        do_reset(6'd0, mf);
        push(1, 6'd0, mf, 23'd0, 23'd0, 1);
        push(1, 6'd0, mf, e_fetch(1), e_fetch(1), 1);
        push(1, 6'd0, mf, e_decode(0), e_decode(0), 1);
        push(1, 6'd0, mf, e_exec(0), e_exec(0), 1);
        push(1, 6'd0, mf, e_exec(1), e_rwb(), 1);
        push(1, 6'd0, mf, e_exec(1), e_fetch(1), 1);
        push(1, 6'd0, mf, e_exec(1), e_decode(0), 1);
        push(1, 6'd0, mf, e_rwb(), e_exec(0), 1);
        push(1, 6'd0, mf, e_fetch(1), e_rwb(), 1);
        cyc = 0;
        while (q.size() > 0) begin
            mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
            @(negedge clk); it = q.pop_front(); checks++;
            if (outv !== it.e) begin errors++; $display("FAIL mul4 c%0d: got %h want %h", cyc, outv, it.e); end
            if (it.chk1) begin
                checks++;
                if (outv1 !== it.e1) begin errors++; $display("FAIL mul1 c%0d: got %h want %h", cyc, outv1, it.e1); end
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_branch();
        logic [5:0] bop [4];
        logic [3:0] balu [4];
        bop  = '{6'b000100, 6'b000001, 6'b000101, 6'b000111};
        balu = '{4'b0001, 4'b1001, 4'b1010, 4'b1011};
        for (int b = 0; b < 4; b++) begin
            do_reset(bop[b], 6'd0);
            push(1, bop[b], 6'd0, 23'd0, 23'd0, 0);
            push(1, bop[b], 6'd0, e_fetch(1), 23'd0, 0);
            push(1, bop[b], 6'd0, e_decode(0), 23'd0, 0);
            push(1, bop[b], 6'd0, e_branch(balu[b], 2'(b)), 23'd0, 0);
            push(0, bop[b], 6'd0, e_fetch(0), 23'd0, 0);
            cyc = 0;
            while (q.size() > 0) begin
                mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
                @(negedge clk); it = q.pop_front(); checks++;
                if (outv !== it.e) begin errors++; $display("FAIL branch%0d c%0d: got %h want %h", b, cyc, outv, it.e); end
                @(posedge clk); #1; cyc++;
            end
        end
    endtask

    task automatic test_imm();
        logic [5:0] iop [3];
        logic [3:0] ialu [3];
        logic       iz [3];
        iop  = '{6'b001000, 6'b001101, 6'b001111};
        ialu = '{4'b0100, 4'b0101, 4'b1000};
        iz   = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            do_reset(iop[k], 6'd0);
            push(1, iop[k], 6'd0, 23'd0, 23'd0, 0);
            push(1, iop[k], 6'd0, e_fetch(1), 23'd0, 0);
            push(1, iop[k], 6'd0, e_decode(0), 23'd0, 0);
            push(1, iop[k], 6'd0, e_iexec(iz[k], ialu[k]), 23'd0, 0);
            push(1, iop[k], 6'd0, e_iwb(), 23'd0, 0);
            push(0, iop[k], 6'd0, e_fetch(0), 23'd0, 0);
            cyc = 0;
            while (q.size() > 0) begin
                mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
                @(negedge clk); it = q.pop_front(); checks++;
                if (outv !== it.e) begin errors++; $display("FAIL imm%0d c%0d: got %h want %h", k, cyc, outv, it.e); end
                @(posedge clk); #1; cyc++;
            end
        end
    endtask

    task automatic test_illegal();
        do_reset(6'b111111, 6'd0);
        push(1, 6'b111111, 6'd0, 23'd0, 23'd0, 0);
        push(1, 6'b111111, 6'd0, e_fetch(1), 23'd0, 0);
        push(1, 6'b111111, 6'd0, e_decode(1), 23'd0, 0);
        push(0, 6'b111111, 6'd0, e_fetch(0), 23'd0, 0);
        push(0, 6'b111111, 6'd0, e_fetch(0), 23'd0, 0);
        cyc = 0;
        while (q.size() > 0) begin
            mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
            @(negedge clk); it = q.pop_front(); checks++;
            if (outv !== it.e) begin errors++; $display("FAIL illegal c%0d: got %h want %h", cyc, outv, it.e); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset(6'b101011, 6'd0);
        push(1, 6'b101011, 6'd0, 23'd0, 23'd0, 0);
        push(1, 6'b101011, 6'd0, e_fetch(1), 23'd0, 0);
        push(1, 6'b101011, 6'd0, e_decode(0), 23'd0, 0);
        push(0, 6'b101011, 6'd0, e_memadr(), 23'd0, 0);
        push(0, 6'b101011, 6'd0, e_memwr(), 23'd0, 0);
        push(0, 6'b101011, 6'd0, e_memwr(), 23'd0, 0);
        cyc = 0;
        while (q.size() > 0) begin
            mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
            @(negedge clk); it = q.pop_front(); checks++;
            if (outv !== it.e) begin errors++; $display("FAIL sw_pre c%0d: got %h want %h", cyc, outv, it.e); end
            @(posedge clk); #1; cyc++;
        end
        #2; rst_n = 1'b0; #1;
        checks++;
        if (outv !== 23'd0) begin errors++; $display("FAIL rst_memwr: got %h want 000000", outv); end

        do_reset(6'd0, 6'b011000);
        push(1, 6'd0, 6'b011000, 23'd0, 23'd0, 0);
        push(1, 6'd0, 6'b011000, e_fetch(1), 23'd0, 0);
        push(1, 6'd0, 6'b011000, e_decode(0), 23'd0, 0);
        push(1, 6'd0, 6'b011000, e_exec(0), 23'd0, 0);
        push(1, 6'd0, 6'b011000, e_exec(1), 23'd0, 0);
        cyc = 0;
        while (q.size() > 0) begin
            mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
            @(negedge clk); it = q.pop_front(); checks++;
            if (outv !== it.e) begin errors++; $display("FAIL mul_pre c%0d: got %h want %h", cyc, outv, it.e); end
            @(posedge clk); #1; cyc++;
        end
        #2; rst_n = 1'b0; #1;
        checks++;
        if (outv !== 23'd0) begin errors++; $display("FAIL rst_mulw: got %h want 000000", outv); end
        checks++;
        if (dut.mul_cnt_q !== 4'd0) begin errors++; $display("FAIL rst_mulw_cnt: got %0d want 0", dut.mul_cnt_q); end

        do_reset(6'd0, 6'd0);
        push(0, 6'd0, 6'd0, 23'd0, 23'd0, 0);
        push(0, 6'd0, 6'd0, e_fetch(0), 23'd0, 0);
        cyc = 0;
        while (q.size() > 0) begin
            mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
            @(negedge clk); it = q.pop_front(); checks++;
            if (outv !== it.e) begin errors++; $display("FAIL rst_recover c%0d: got %h want %h", cyc, outv, it.e); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset(6'b001000, 6'd0);
        push(1, 6'b001000, 6'd0, 23'd0, 23'd0, 0);
        push(1, 6'b001000, 6'd0, e_fetch(1), 23'd0, 0);
        push(1, 6'b001000, 6'd0, e_decode(0), 23'd0, 0);
        push(1, 6'b001000, 6'd0, e_iexec(0, 4'b0100), 23'd0, 0);
        push(1, 6'b001000, 6'd0, e_iwb(), 23'd0, 0);
        push(1, 6'b100011, 6'd0, e_fetch(1), 23'd0, 0);
        push(1, 6'b100011, 6'd0, e_decode(0), 23'd0, 0);
        push(1, 6'b100011, 6'd0, e_memadr(), 23'd0, 0);
        push(1, 6'b100011, 6'd0, e_memrd(), 23'd0, 0);
        push(1, 6'b100011, 6'd0, e_memwb(), 23'd0, 0);
        push(1, 6'b000010, 6'd0, e_fetch(1), 23'd0, 0);
        push(1, 6'b000010, 6'd0, e_decode(0), 23'd0, 0);
        push(1, 6'b000010, 6'd0, e_jump(), 23'd0, 0);
        push(0, 6'b000010, 6'd0, e_fetch(0), 23'd0, 0);
        cyc = 0;
        while (q.size() > 0) begin
            mem_ready = q[0].rdy; op = q[0].op; funct = q[0].fn;
            @(negedge clk); it = q.pop_front(); checks++;
            if (outv !== it.e) begin errors++; $display("FAIL b2b c%0d: got %h want %h", cyc, outv, it.e); end
            checks++;
            if ((mr && mw) || (rw && pcw)) begin errors++; $display("FAIL b2b_excl c%0d: got %h want no overlap", cyc, outv); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_mul();
        test_branch();
        test_imm();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder: a Moore FSM that sequences the shared-ALU, shared-memory datapath over FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK cycles.
- Adds memory ready handshaking, a parametrised multi-cycle multiply wait, and illegal-opcode detection.
- Sits between the instruction register and the datapath muxes, register file and unified memory.

Parameters:
OP_W, 6, opcode and funct field width
ALUOP_W, 4, ALU_op_o width (encodings below)
MUL_CYCLES, 4, cycles the multiplier needs; legal range 1..15
MULT_FUNCT, 6'b011000, R-type funct selecting multiply

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
instr_op_i  in  OP_W  opcode from instruction register
funct_i  in  OP_W  funct field from instruction register
mem_ready_i  in  1  memory completes the current read/write this cycle
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  PC load if ALU branch condition true
IorD_o  out  1  memory address: 0=PC, 1=ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  instruction register load
MemtoReg_o  out  1  writeback data: 0=ALUOut, 1=MDR
RegDst_o  out  1  destination: 0=rt, 1=rd
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0=PC, 1=rs
ALUSrcB_o  out  2  00=rt, 01=const 4, 10=extended imm, 11=sign-ext imm<<2
ZeroExt_o  out  1  immediate extension: 1=zero, 0=sign
ALU_op_o  out  ALUOP_W  ALU control code
PCSource_o  out  2  00=ALU result, 01=ALUOut, 10=jump target
branchType_o  out  2  0=beq, 1=bgez, 2=bnez, 3=bgt
illegal_o  out  1  one-cycle pulse on an unsupported opcode
busy_mul_o  out  1  high while in MULW

Behaviour:
- Reset (rst_i low, async): state=IDLE, mul counter=0. Every output is 0 in IDLE. After release, IDLE goes to FETCH on the next edge.
- Moore outputs, decoded only from registered state. The exceptions are the FETCH strobes gated by mem_ready_i, listed below.
- Any output not listed for a state is 0.
- ALU_op encodings: add 0000, beq 0001, R-type 0010, addi 0100, ori 0101, lui 1000, bgez 1001, bnez 1010, bgt 1011.

States:
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=0000.
  - IRWrite and PCWrite are high only in a cycle where mem_ready_i=1.
  - Stays in FETCH while mem_ready_i=0; goes to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=0000 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC
  - 001000, 001101, 001111 -> IEXEC
  - 100011, 101011 -> MEMADR
  - 000100, 000001, 000101, 000111 -> BRANCH
  - 000010 -> JUMP
  - anything else -> FETCH, with illegal_o=1 for this cycle
- EXEC: ALUSrcA=1, ALUSrcB=00, ALU_op=0010.
  - If funct_i==MULT_FUNCT, load counter with MUL_CYCLES-1 and go to MULW; otherwise go to RWB.
- MULW: busy_mul_o=1, ALU operands held as in EXEC. Counter decrements each cycle; at 0 go to RWB.
  - With MUL_CYCLES=1, EXEC goes straight to RWB, so MULW is skipped.
- RWB: RegDst=1, RegWrite=1, MemtoReg=0 -> FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ZeroExt=1 for ori/lui and 0 for addi; ALU_op per opcode -> IWB.
- IWB: RegDst=0, RegWrite=1 -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_op=0000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready_i=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready_i=1, then goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, PCWriteCond=1, PCSource=01, ALU_op and branchType per opcode -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.

Invariants and boundary conditions:
- Opcode and funct are sampled only in DECODE and EXEC. The instruction register does not change outside FETCH.
- MemRead and MemWrite are never high together. RegWrite and PCWrite are never high together.
- Reset mid-operation (any state, including MULW or a memory stall) forces IDLE and clears the counter. No write strobe is issued on the cycle reset asserts.
- mem_ready_i is ignored outside FETCH, MEMRD and MEMWR.
- Undefined state encodings recover to IDLE.

Test Plan:
- Reset release, mem_ready_i=1, op=000000 funct=100000 -> IDLE, FETCH, DECODE, EXEC, RWB, FETCH (5 edges); RegWrite=1 and RegDst=1 only in RWB; ALU_op=0010 in EXEC.
- lw with mem_ready_i low for 3 cycles in MEMRD -> MemRead=1, IorD=1 held for 4 cycles; MEMWB asserts RegWrite=1, MemtoReg=1; no MemWrite at any point.
- Multiply (funct 011000), MUL_CYCLES=4 -> busy_mul_o high exactly 3 cycles, then RWB; rerun with MUL_CYCLES=1 -> MULW never entered.
- bgt (000111) -> BRANCH with PCWriteCond=1, branchType=3, ALU_op=1011, PCSource=01; jump (000010) -> PCWrite=1, PCSource=10 for one cycle.
- Opcode 111111 -> DECODE pulses illegal_o for 1 cycle, next state FETCH, no RegWrite, MemWrite or PCWrite in that instruction.
- rst_i dropped mid-MEMWR and mid-MULW -> all outputs 0 immediately (async); after release, IDLE then FETCH, counter=0.
